// File: rtl/reg_bank_sb_if.sv
// Bus bundle between the IITB-RISC pipeline stages and reg_bank_sb.
// The master side (decode/writeback/fetch) drives indices, writes, PC and issue.
interface reg_bank_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              rd_busy_1;
  logic              rd_busy_2;
  logic              wr_en_a;
  logic [ADDR_W-1:0] wr_add_a;
  logic [DATA_W-1:0] wr_data_a;
  logic              wr_en_b;
  logic [ADDR_W-1:0] wr_add_b;
  logic [DATA_W-1:0] wr_data_b;
  logic              pc_en;
  logic [DATA_W-1:0] pc;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_add;
  logic [NREGS-1:0]  busy_vec;

  modport master (
    output rd_addr_1, rd_addr_2, wr_en_a, wr_add_a, wr_data_a,
           wr_en_b, wr_add_b, wr_data_b, pc_en, pc, issue_en, issue_add,
    input  rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, busy_vec
  );

  modport slave (
    input  rd_addr_1, rd_addr_2, wr_en_a, wr_add_a, wr_data_a,
           wr_en_b, wr_add_b, wr_data_b, pc_en, pc, issue_en, issue_add,
    output rd_data_1, rd_data_2, rd_busy_1, rd_busy_2, busy_vec
  );
endinterface

// File: rtl/reg_bank_sb.sv
// Register bank with dedicated PC, two write ports, optional write-to-read
// bypass and a per-register busy scoreboard for decode stalls.
module reg_bank_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int PC_IDX = 7,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         rst,
  reg_bank_sb_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0] regs_r [NREGS];
  logic [NREGS-1:0]  busy_r;
  logic [NREGS-1:0]  busy_nxt_s;
  logic              wr_a_eff_s;
  logic              wr_b_eff_s;
  logic              issue_eff_s;
  logic [ADDR_W-1:0] rd_addr_s [2];
  logic [DATA_W-1:0] rd_data_s [2];
  logic              rd_busy_s [2];

  // The PC slot is reachable only through pc/pc_en, never through A/B/issue.
  assign wr_a_eff_s  = bus.wr_en_a  && (bus.wr_add_a  != PC_ADDR);
  assign wr_b_eff_s  = bus.wr_en_b  && (bus.wr_add_b  != PC_ADDR);
  assign issue_eff_s = bus.issue_en && (bus.issue_add != PC_ADDR);

  assign rd_addr_s[0]  = bus.rd_addr_1;
  assign rd_addr_s[1]  = bus.rd_addr_2;
  assign bus.rd_data_1 = rd_data_s[0];
  assign bus.rd_data_2 = rd_data_s[1];
  assign bus.rd_busy_1 = rd_busy_s[0];
  assign bus.rd_busy_2 = rd_busy_s[1];
  assign bus.busy_vec  = busy_r;

  // Register storage: PC from fetch, port B (younger producer) over port A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == PC_IDX) begin
          if (bus.pc_en) begin
            regs_r[i] <= bus.pc;
          end else begin
            regs_r[i] <= regs_r[i];
          end
        end else if (wr_b_eff_s && (bus.wr_add_b == ADDR_W'(i))) begin
          regs_r[i] <= bus.wr_data_b;
        end else if (wr_a_eff_s && (bus.wr_add_a == ADDR_W'(i))) begin
          regs_r[i] <= bus.wr_data_a;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Scoreboard next state: a same-cycle issue outranks a writeback clear.
  always_comb begin
    busy_nxt_s = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_nxt_s[i] = (i == PC_IDX) ? 1'b0 :
                      (issue_eff_s && (bus.issue_add == ADDR_W'(i))) ? 1'b1 :
                      (wr_a_eff_s  && (bus.wr_add_a  == ADDR_W'(i))) ? 1'b0 :
                      (wr_b_eff_s  && (bus.wr_add_b  == ADDR_W'(i))) ? 1'b0 :
                      busy_r[i];
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Read muxes; a forwarded write also hides the pending-busy for that index.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data_s[p] = regs_r[rd_addr_s[p]];
      rd_busy_s[p] = busy_r[rd_addr_s[p]];
      if ((BYPASS != 0) && wr_b_eff_s && (bus.wr_add_b == rd_addr_s[p])) begin
        rd_data_s[p] = bus.wr_data_b;
        rd_busy_s[p] = 1'b0;
      end else if ((BYPASS != 0) && wr_a_eff_s && (bus.wr_add_a == rd_addr_s[p])) begin
        rd_data_s[p] = bus.wr_data_a;
        rd_busy_s[p] = 1'b0;
      end else begin
        rd_data_s[p] = regs_r[rd_addr_s[p]];
        rd_busy_s[p] = busy_r[rd_addr_s[p]];
      end
    end
  end
endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed-vector bench for reg_bank_sb: bypass and non-bypass 16-bit banks
// sharing stimulus, plus a 32-bit / 16-entry bank.
module tb_reg_bank_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reg_bank_sb_if #(.DATA_W(16), .ADDR_W(3)) ifa ();
  reg_bank_sb_if #(.DATA_W(16), .ADDR_W(3)) ifb ();
  reg_bank_sb_if #(.DATA_W(32), .ADDR_W(4)) ifw ();

  assign ifb.rd_addr_1 = ifa.rd_addr_1;
  assign ifb.rd_addr_2 = ifa.rd_addr_2;
  assign ifb.wr_en_a   = ifa.wr_en_a;
  assign ifb.wr_add_a  = ifa.wr_add_a;
  assign ifb.wr_data_a = ifa.wr_data_a;
  assign ifb.wr_en_b   = ifa.wr_en_b;
  assign ifb.wr_add_b  = ifa.wr_add_b;
  assign ifb.wr_data_b = ifa.wr_data_b;
  assign ifb.pc_en     = ifa.pc_en;
  assign ifb.pc        = ifa.pc;
  assign ifb.issue_en  = ifa.issue_en;
  assign ifb.issue_add = ifa.issue_add;

  reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .PC_IDX(7), .BYPASS(1))
    u_b1 (.clk(clk), .rst(rst), .bus(ifa.slave));
  reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .PC_IDX(7), .BYPASS(0))
    u_b0 (.clk(clk), .rst(rst), .bus(ifb.slave));
  reg_bank_sb #(.DATA_W(32), .ADDR_W(4), .PC_IDX(15), .BYPASS(1))
    u_w (.clk(clk), .rst(rst), .bus(ifw.slave));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifa.wr_en_a = 1'b0; ifa.wr_en_b = 1'b0; ifa.pc_en = 1'b0; ifa.issue_en = 1'b0;
    ifw.wr_en_a = 1'b0; ifw.wr_en_b = 1'b0; ifw.pc_en = 1'b0; ifw.issue_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    ifa.rd_addr_1 = 3'd3; ifa.rd_addr_2 = 3'd7;
    ifa.wr_add_a = 3'd0; ifa.wr_data_a = 16'h0; ifa.wr_add_b = 3'd0; ifa.wr_data_b = 16'h0;
    ifa.pc = 16'h0; ifa.issue_add = 3'd0;
    ifw.rd_addr_1 = 4'd0; ifw.rd_addr_2 = 4'd0;
    ifw.wr_add_a = 4'd0; ifw.wr_data_a = 32'h0; ifw.wr_add_b = 4'd0; ifw.wr_data_b = 32'h0;
    ifw.pc = 32'h0; ifw.issue_add = 4'd0;
    #1;
    check_val("rst_rd1", ifa.rd_data_1, 64'h0);
    check_val("rst_bvec", ifa.busy_vec, 64'h0);
    tick(); tick();
    #2 rst = 1'b0;

    // Write R3 and issue R1, then assert reset mid-cycle.
    tick();
    ifa.wr_en_a = 1'b1; ifa.wr_add_a = 3'd3; ifa.wr_data_a = 16'h1234;
    ifa.issue_en = 1'b1; ifa.issue_add = 3'd1;
    tick(); idle(); #1;
    check_val("wr_r3_b1", ifa.rd_data_1, 64'h1234);
    check_val("wr_r3_b0", ifb.rd_data_1, 64'h1234);
    check_val("issue_r1", ifa.busy_vec, 64'h02);
    #2 rst = 1'b1; #1;
    check_val("midrst_rd1", ifa.rd_data_1, 64'h0);
    check_val("midrst_bvec", ifa.busy_vec, 64'h0);
    check_val("midrst_pc", ifa.rd_data_2, 64'h0);
    ifa.wr_en_a = 1'b1; ifa.wr_data_a = 16'h5555; ifa.pc_en = 1'b1; ifa.pc = 16'h0077;
    ifa.issue_en = 1'b1; ifa.issue_add = 3'd3;
    tick(); idle(); #2 rst = 1'b0;
    tick();
    check_val("rstdisc_r3", ifa.rd_data_1, 64'h0);
    check_val("rstdisc_pc", ifa.rd_data_2, 64'h0);
    check_val("rstdisc_bv", ifa.busy_vec, 64'h0);

    // Dual-write collision on R2: port B wins.
    ifa.rd_addr_1 = 3'd2;
    ifa.wr_en_a = 1'b1; ifa.wr_add_a = 3'd2; ifa.wr_data_a = 16'h1111;
    ifa.wr_en_b = 1'b1; ifa.wr_add_b = 3'd2; ifa.wr_data_b = 16'h2222;
    #1;
    check_val("coll_byp1", ifa.rd_data_1, 64'h2222);
    check_val("coll_byp0", ifb.rd_data_1, 64'h0);
    tick(); idle(); #1;
    check_val("coll_post1", ifa.rd_data_1, 64'h2222);
    check_val("coll_post0", ifb.rd_data_1, 64'h2222);
    check_val("coll_bv", ifa.busy_vec, 64'h0);

    // Distinct indices on both ports in one cycle.
    ifa.rd_addr_1 = 3'd1; ifa.rd_addr_2 = 3'd0;
    ifa.wr_en_a = 1'b1; ifa.wr_add_a = 3'd1; ifa.wr_data_a = 16'hA1A1;
    ifa.wr_en_b = 1'b1; ifa.wr_add_b = 3'd0; ifa.wr_data_b = 16'hB0B0;
    tick(); idle(); #1;
    check_val("dual_r1", ifb.rd_data_1, 64'hA1A1);
    check_val("dual_r0", ifb.rd_data_2, 64'hB0B0);

    // PC protection: port A and issue to R7 ignored; pc_en loads.
    ifa.rd_addr_1 = 3'd7;
    ifa.wr_en_a = 1'b1; ifa.wr_add_a = 3'd7; ifa.wr_data_a = 16'hDEAD;
    ifa.pc_en = 1'b1; ifa.pc = 16'h0042;
    ifa.issue_en = 1'b1; ifa.issue_add = 3'd7;
    #1;
    check_val("pc_nobyp", ifa.rd_data_1, 64'h0);
    tick(); idle(); #1;
    check_val("pc_load", ifa.rd_data_1, 64'h0042);
    check_val("pc_bv", ifa.busy_vec, 64'h0);
    ifa.pc = 16'h0099;
    tick();
    check_val("pc_hold", ifa.rd_data_1, 64'h0042);

    // Scoreboard issue then clear by writeback.
    ifa.rd_addr_1 = 3'd5;
    ifa.issue_en = 1'b1; ifa.issue_add = 3'd5;
    #1;
    check_val("iss_same", ifa.rd_busy_1, 64'h0);
    tick(); idle(); #1;
    check_val("iss_bv", ifa.busy_vec, 64'h20);
    check_val("iss_rdb", ifa.rd_busy_1, 64'h1);
    ifa.wr_en_a = 1'b1; ifa.wr_add_a = 3'd5; ifa.wr_data_a = 16'h00AB;
    #1;
    check_val("clr_rdb1", ifa.rd_busy_1, 64'h0);
    check_val("clr_rdd1", ifa.rd_data_1, 64'h00AB);
    check_val("clr_rdb0", ifb.rd_busy_1, 64'h1);
    check_val("clr_rdd0", ifb.rd_data_1, 64'h0);
    tick(); idle(); #1;
    check_val("clr_bv", ifa.busy_vec, 64'h0);
    check_val("clr_post0", ifb.rd_data_1, 64'h00AB);

    // Set beats clear on R4.
    ifa.rd_addr_2 = 3'd4;
    ifa.issue_en = 1'b1; ifa.issue_add = 3'd4;
    tick(); idle(); #1;
    check_val("sbc_pre", ifa.busy_vec, 64'h10);
    ifa.issue_en = 1'b1; ifa.issue_add = 3'd4;
    ifa.wr_en_b = 1'b1; ifa.wr_add_b = 3'd4; ifa.wr_data_b = 16'h0F0F;
    #1;
    check_val("sbc_rdb", ifa.rd_busy_2, 64'h0);
    check_val("sbc_rdd", ifa.rd_data_2, 64'h0F0F);
    tick(); idle(); #1;
    check_val("sbc_bv", ifa.busy_vec, 64'h10);
    check_val("sbc_r4", ifa.rd_data_2, 64'h0F0F);
    check_val("sbc_rdb2", ifa.rd_busy_2, 64'h1);

    // Wide bank: R14 write, R15 (PC) protected, 16-entry scoreboard.
    ifw.rd_addr_1 = 4'd14; ifw.rd_addr_2 = 4'd15;
    ifw.wr_en_a = 1'b1; ifw.wr_add_a = 4'd14; ifw.wr_data_a = 32'hCAFEBABE;
    ifw.wr_en_b = 1'b1; ifw.wr_add_b = 4'd15; ifw.wr_data_b = 32'h12345678;
    ifw.issue_en = 1'b1; ifw.issue_add = 4'd15;
    #1;
    check_val("w_byp", ifw.rd_data_1, 64'hCAFEBABE);
    check_val("w_pcbyp", ifw.rd_data_2, 64'h0);
    tick(); idle(); #1;
    check_val("w_r14", ifw.rd_data_1, 64'hCAFEBABE);
    check_val("w_r15", ifw.rd_data_2, 64'h0);
    check_val("w_bv0", ifw.busy_vec, 64'h0);
    ifw.issue_en = 1'b1; ifw.issue_add = 4'd14;
    ifw.pc_en = 1'b1; ifw.pc = 32'h87654321;
    tick(); idle(); #1;
    check_val("w_bv", ifw.busy_vec, 64'h4000);
    check_val("w_pc", ifw.rd_data_2, 64'h87654321);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank for the pipelined IITB-RISC core: two asynchronous read ports, two write ports (pipeline writeback plus load-multiple), a dedicated PC register, optional same-cycle write-to-read bypass, and a per-register busy scoreboard used by decode to stall on pending writes. It sits between decode (reads, issue) and writeback (writes), and receives the next PC from fetch.

## Interface

- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W
- PC_IDX, 7, index of the PC register; architectural writes to it are ignored
- BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored value only

- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- rd_addr_1, rd_addr_2  in  ADDR_W  read indices
- rd_data_1, rd_data_2  out  DATA_W  read data, combinational
- rd_busy_1, rd_busy_2  out  1  scoreboard status of the read index, combinational
- wr_en_a  in  1  writeback write enable
- wr_add_a  in  ADDR_W  writeback write index
- wr_data_a  in  DATA_W  writeback write data
- wr_en_b  in  1  load-multiple write enable
- wr_add_b  in  ADDR_W  load-multiple write index
- wr_data_b  in  DATA_W  load-multiple write data
- pc_en  in  1  load PC register this cycle
- pc  in  DATA_W  next PC value
- issue_en  in  1  mark a register as pending write
- issue_add  in  ADDR_W  register marked by issue_en
- busy_vec  out  NREGS  full scoreboard, registered

## Operation

- Storage: NREGS x DATA_W registers plus busy[NREGS-1:0].
- Write port effective only when wr_en_x=1 and wr_add_x != PC_IDX.
- Both ports effective on the same index: port B wins (load-multiple is the younger producer).
- PC register: loaded from pc when pc_en=1, else holds. Never written by port A/B.
- Read (BYPASS=1): if rd_addr matches an effective write this cycle, return that write data (B over A); else stored value. rd_addr = PC_IDX always returns stored PC (no bypass from pc input).
- Read (BYPASS=0): stored value only.
- Scoreboard clear: each effective write clears busy[wr_add].
- Scoreboard set: issue_en=1 and issue_add != PC_IDX sets busy[issue_add]. Set wins over a same-cycle clear on the same index.
- busy[PC_IDX] is constant 0.
- rd_busy_n = busy[rd_addr_n], except with BYPASS=1 it reads 0 when an effective write to rd_addr_n occurs this cycle (data is being forwarded), unless issue_en targets the same index this cycle (still reads 0 for this cycle; the new busy appears next cycle).
- busy_vec is the registered busy array (no bypass).

## Timing

- Reset (async, any time): all registers including PC = 0, busy = 0; hence rd_data_* = 0, rd_busy_* = 0, busy_vec = 0 immediately, independent of clk. Writes, issues or pc_en in cycles where rst=1 are discarded.
- Write latency: stored value visible on the edge; with BYPASS=1 visible combinationally in the same cycle, with BYPASS=0 from the cycle after the edge.
- PC latency: pc value readable one cycle after the pc_en edge.
- Issue latency: busy visible on rd_busy/busy_vec from the cycle after issue_en.
- No handshake: every enable is single-cycle, fully pipelined, one op per port per cycle.
- Writes to an index not marked busy are legal and leave busy at 0.

## Test plan

- Reset: write R3=0x1234, assert rst mid-cycle -> rd_data_1(R3)=0x0000 and busy_vec=0 before the next edge; PC reads 0x0000.
- Dual-write collision: wr_a(R2,0x1111) and wr_b(R2,0x2222) same cycle, BYPASS=1 -> rd_data_1(R2)=0x2222 same cycle and after edge; BYPASS=0 -> old value same cycle, 0x2222 after edge.
- PC protection: wr_a(R7,0xDEAD), pc_en=1, pc=0x0042 -> R7 reads 0x0042 next cycle; issue_en to R7 leaves busy_vec[7]=0.
- Scoreboard: issue R5 -> busy_vec=0x20 next cycle, rd_busy(R5)=1; wr_a(R5,0x00AB) -> same cycle rd_busy=0 with rd_data=0x00AB (BYPASS=1), busy_vec=0x00 after edge.
- Set beats clear: issue R4 and wr_b(R4,0x0F0F) same cycle while busy[4]=1 -> after edge busy_vec[4]=1, R4=0x0F0F.
- Parametric: DATA_W=32, ADDR_W=4, PC_IDX=15 -> write R14=0xCAFEBABE readable, busy_vec width 16, R15 write ignored.
